obstacle_avoid_ctrl: RTL

//  Downstream consumer of the ultrasonic proximity stage's crash flag.

---
 rtl/robot_pkg.sv | 20 ++
 rtl/pwm_channel.sv | 32 +++
 rtl/obstacle_avoid_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/robot_pkg.sv
// rtl/robot_pkg.sv - shared state encoding, direction constants and width helper
package robot_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRIVE   = 3'd1,
    BRAKE   = 3'd2,
    REVERSE = 3'd3,
    TURN    = 3'd4,
    FAULT   = 3'd5
  } stateT;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one motor output stage: duty/dir latched at counter wrap
module pwm_channel #(
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wrap,
  input  logic          forceOff,
  input  logic [CW-1:0] counter,
  input  logic [CW-1:0] targetDuty,
  input  logic          targetDir,
  output logic          pwm,
  output logic          dir
);

  logic [CW-1:0] dutyLatched;

  // forceOff kills the pulse right away; dir only ever moves at a period boundary
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dutyLatched <= '0;
      dir         <= 1'b0;
    end else begin
      if (forceOff)  dutyLatched <= '0;
      else if (wrap) dutyLatched <= targetDuty;
      if (wrap)      dir         <= targetDir;
    end
  end

  assign pwm = (counter < dutyLatched);

endmodule

// File: rtl/obstacle_avoid_ctrl.sv
// rtl/obstacle_avoid_ctrl.sv - crash-flag conditioning and rover avoidance FSM
module obstacle_avoid_ctrl
  import robot_pkg::*;
#(
  parameter int PWM_PERIOD   = 1000,
  parameter int DUTY_FWD     = 700,
  parameter int DUTY_REV     = 500,
  parameter int DUTY_TURN    = 600,
  parameter int DEBOUNCE_CYC = 16,
  parameter int BRAKE_CYC    = 50000,
  parameter int REVERSE_CYC  = 2000000,
  parameter int TURN_CYC     = 1500000,
  parameter int MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       is_crash,
  output logic       left_pwm,
  output logic       left_dir,
  output logic       right_pwm,
  output logic       right_dir,
  output logic [2:0] state,
  output logic       fault
);

  localparam int CW  = $clog2(maxOf(PWM_PERIOD, maxOf(DUTY_FWD, maxOf(DUTY_REV, DUTY_TURN))) + 1);
  localparam int TW  = $clog2(maxOf(BRAKE_CYC, maxOf(REVERSE_CYC, TURN_CYC)) + 1);
  localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
  localparam int RW  = $clog2(MAX_RETRY + 1);

  logic           syncA, syncB, crashDb;
  logic [DBW-1:0] dbCnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      syncA   <= 1'b0;
      syncB   <= 1'b0;
      crashDb <= 1'b0;
      dbCnt   <= '0;
    end else begin
      syncA <= is_crash;
      syncB <= syncA;
      if (syncB == crashDb) begin
        dbCnt <= '0;
      end else if (dbCnt == DBW'(DEBOUNCE_CYC - 1)) begin
        crashDb <= syncB;
        dbCnt   <= '0;
      end else begin
        dbCnt <= dbCnt + 1'b1;
      end
    end
  end

  stateT         curState, nextState;
  logic [TW-1:0] timer;
  logic [RW-1:0] retry, nextRetry;

  always_comb begin
    nextState = curState;
    nextRetry = retry;
    if (!enable) begin
      nextState = IDLE;
      nextRetry = '0;
    end else begin
      case (curState)
        IDLE: begin
          nextState = DRIVE;
          nextRetry = '0;
        end
        DRIVE:   if (crashDb) nextState = BRAKE;
        BRAKE:   if (timer == TW'(BRAKE_CYC - 1)) nextState = REVERSE;
        REVERSE: if (timer == TW'(REVERSE_CYC - 1)) nextState = TURN;
        TURN: begin
          if (timer == TW'(TURN_CYC - 1)) begin
            if (!crashDb) begin
              nextState = DRIVE;
              nextRetry = '0;
            end else if (retry < RW'(MAX_RETRY - 1)) begin
              nextState = BRAKE;
              nextRetry = retry + 1'b1;
            end else begin
              nextState = FAULT;
            end
          end
        end
        FAULT:   nextState = FAULT;
        default: nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      curState <= IDLE;
      retry    <= '0;
      timer    <= '0;
    end else begin
      curState <= nextState;
      retry    <= nextRetry;
      timer    <= (nextState != curState) ? '0 : timer + 1'b1;
    end
  end

  // Targets follow the state being entered so a wrap on the transition edge already loads it
  logic [CW-1:0] targetDuty;
  logic          leftTargetDir, rightTargetDir, forceOff;

  always_comb begin
    targetDuty     = '0;
    leftTargetDir  = left_dir;
    rightTargetDir = right_dir;
    case (nextState)
      IDLE: begin
        leftTargetDir  = 1'b0;
        rightTargetDir = 1'b0;
      end
      DRIVE: begin
        targetDuty     = CW'(DUTY_FWD);
        leftTargetDir  = DIR_FWD;
        rightTargetDir = DIR_FWD;
      end
      REVERSE: begin
        targetDuty     = CW'(DUTY_REV);
        leftTargetDir  = DIR_REV;
        rightTargetDir = DIR_REV;
      end
      TURN: begin
        targetDuty     = CW'(DUTY_TURN);
        leftTargetDir  = DIR_FWD;
        rightTargetDir = DIR_REV;
      end
      default: targetDuty = '0;
    endcase
  end

  assign forceOff = (nextState == IDLE) || (nextState == BRAKE) || (nextState == FAULT);

  logic [CW-1:0] pwmCnt;
  logic          wrap;

  assign wrap = (pwmCnt == CW'(PWM_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) pwmCnt <= '0;
    else        pwmCnt <= wrap ? '0 : pwmCnt + 1'b1;
  end

  pwm_channel #(.CW(CW)) leftChan (
    .clk        (clk),
    .rst_n      (rst_n),
    .wrap       (wrap),
    .forceOff   (forceOff),
    .counter    (pwmCnt),
    .targetDuty (targetDuty),
    .targetDir  (leftTargetDir),
    .pwm        (left_pwm),
    .dir        (left_dir)
  );

  pwm_channel #(.CW(CW)) rightChan (
    .clk        (clk),
    .rst_n      (rst_n),
    .wrap       (wrap),
    .forceOff   (forceOff),
    .counter    (pwmCnt),
    .targetDuty (targetDuty),
    .targetDir  (rightTargetDir),
    .pwm        (right_pwm),
    .dir        (right_dir)
  );

  assign state = curState;
  assign fault = (curState == FAULT);

endmodule
